// File: rtl/gradient_engine.sv
// gradient_engine: 3-row Sobel gradient/magnitude/direction engine, LANES columns per clock; `GRADIENT_THRESH_EN adds thresh/edge_map.
module gradient_engine #(
  parameter int WIDTH = 16,
  parameter int PIX_W = 8,
  parameter int LANES = 2,
  parameter int MAG_W = 8,
  parameter int MAG_SHIFT = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             row_valid,
  input  logic                             frame_start,
  input  logic [WIDTH*PIX_W-1:0]           row_in,
`ifdef GRADIENT_THRESH_EN
  input  logic [MAG_W-1:0]                 thresh,
  output logic [WIDTH-3:0]                 edge_map,
`endif
  output logic                             busy,
  output logic                             done,
  output logic [(WIDTH-2)*(PIX_W+3)-1:0]   grad_x,
  output logic [(WIDTH-2)*(PIX_W+3)-1:0]   grad_y,
  output logic [(WIDTH-2)*MAG_W-1:0]       grad_mag,
  output logic [(WIDTH-2)*2-1:0]           grad_angle
);
  localparam int OC = WIDTH - 2;
  localparam int GW = PIX_W + 3;
  localparam int NG = (OC + LANES - 1) / LANES;
  localparam int GB = NG > 1 ? $clog2(NG) : 1;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state, state_n;
  logic [GB-1:0] g;
  logic accept, last;
  logic [PIX_W-1:0] r0 [WIDTH];
  logic [PIX_W-1:0] r1 [WIDTH];
  logic [PIX_W-1:0] r2 [WIDTH];
  logic [PIX_W-1:0] rin [WIDTH];
  logic [PIX_W-1:0] p [LANES][3][3];
  logic signed [GW-1:0] lx [LANES];
  logic signed [GW-1:0] ly [LANES];
  logic [MAG_W-1:0] lm [LANES];
  logic [1:0] la [LANES];
`ifdef GRADIENT_THRESH_EN
  logic [MAG_W-1:0] thr;
`endif

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v, input logic dbl);
    return $signed(dbl ? GW'({v, 1'b0}) : GW'(v));
  endfunction

  function automatic logic [31:0] absw(input logic signed [GW-1:0] v);
    return 32'(v < 0 ? -v : v);
  endfunction

  assign accept = state == IDLE && row_valid;
  assign last = g == GB'(NG - 1);

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state == IDLE ? (accept ? COMPUTE : IDLE) :
              state == COMPUTE ? (last ? DONE : COMPUTE) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end

  always_comb
    for (int i = 0; i < WIDTH; i++) rin[i] = row_in[i*PIX_W +: PIX_W];

  // Route the current group's 3x3 windows onto the lanes
  always_comb begin
    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < 3; k++)
        for (int m = 0; m < 3; m++) p[l][k][m] = '0;
    for (int j = 0; j < OC; j++)
      if (GB'(j / LANES) == g)
        for (int m = 0; m < 3; m++) begin
          p[j%LANES][0][m] = r0[j+m];
          p[j%LANES][1][m] = r1[j+m];
          p[j%LANES][2][m] = r2[j+m];
        end
  end

  always_comb
    for (int l = 0; l < LANES; l++) begin
      logic [31:0] ax, ay, s;
      lx[l] = ext(p[l][0][2], 1'b0) - ext(p[l][0][0], 1'b0) + ext(p[l][1][2], 1'b1)
            - ext(p[l][1][0], 1'b1) + ext(p[l][2][2], 1'b0) - ext(p[l][2][0], 1'b0);
      ly[l] = ext(p[l][0][0], 1'b0) + ext(p[l][0][1], 1'b1) + ext(p[l][0][2], 1'b0)
            - ext(p[l][2][0], 1'b0) - ext(p[l][2][1], 1'b1) - ext(p[l][2][2], 1'b0);
      ax = absw(lx[l]);
      ay = absw(ly[l]);
      s = (ax + ay) >> MAG_SHIFT;
      lm[l] = s > 32'((1 << MAG_W) - 1) ? '1 : MAG_W'(s);
      la[l] = (ax == 0 && ay == 0) ? 2'd0 :
              5 * ay < 2 * ax ? 2'd0 :
              2 * ay > 5 * ax ? 2'd2 :
              (lx[l][GW-1] == ly[l][GW-1] || ax == 0 || ay == 0) ? 2'd1 : 2'd3;
    end

  always_ff @(posedge clk)
    if (rst) begin
      g <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r0[i] <= '0;
        r1[i] <= '0;
        r2[i] <= '0;
      end
      grad_x <= '0;
      grad_y <= '0;
      grad_mag <= '0;
      grad_angle <= '0;
`ifdef GRADIENT_THRESH_EN
      thr <= '0;
      edge_map <= '0;
`endif
    end else begin
      if (accept) begin
        g <= '0;
        for (int i = 0; i < WIDTH; i++) begin
          r0[i] <= frame_start ? rin[i] : r1[i];
          r1[i] <= frame_start ? rin[i] : r2[i];
          r2[i] <= rin[i];
        end
`ifdef GRADIENT_THRESH_EN
        thr <= thresh;
`endif
      end
      if (state == COMPUTE) begin
        g <= g + 1'b1;
        for (int j = 0; j < OC; j++)
          if (GB'(j / LANES) == g) begin
            grad_x[j*GW +: GW] <= lx[j%LANES];
            grad_y[j*GW +: GW] <= ly[j%LANES];
            grad_mag[j*MAG_W +: MAG_W] <= lm[j%LANES];
            grad_angle[j*2 +: 2] <= la[j%LANES];
`ifdef GRADIENT_THRESH_EN
            edge_map[j] <= lm[j%LANES] > thr;
`endif
          end
      end
    end
endmodule

// File: doc/gradient_engine.md
Name: gradient_engine

Overview:
- Parametrised successor to the fixed 16-pixel Sobel gradient controller.
- Keeps its own 3-row line history.
- Computes Sobel Gx/Gy, saturated magnitude and a 2-bit quantised direction for WIDTH-2 interior columns, LANES columns per clock, under an accept/busy/done handshake.
- Sits between the pixel line fetcher and the non-max-suppression/hysteresis stage.

Parameters:
WIDTH, 16, pixels per input row (>=3)
PIX_W, 8, bits per pixel (unsigned)
LANES, 2, columns computed per COMPUTE cycle (1..WIDTH-2)
MAG_W, 8, magnitude output width
MAG_SHIFT, 3, right shift applied to |Gx|+|Gy|

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
row_valid  in  1  new row present on row_in; accepted only when busy=0
frame_start  in  1  qualifies row_valid: row replicated into all three history rows
row_in  in  WIDTH*PIX_W  packed row, element i = column i
busy  out  1  high in COMPUTE and DONE
done  out  1  one-cycle pulse, all outputs for the row valid
grad_x  out  (WIDTH-2)*(PIX_W+3)  signed Gx per output column
grad_y  out  (WIDTH-2)*(PIX_W+3)  signed Gy per output column
grad_mag  out  (WIDTH-2)*MAG_W  saturated magnitude
grad_angle  out  (WIDTH-2)*2  quantised direction

Behaviour:
- Reset (rst high at an edge): state=IDLE, group counter=0, history rows=0, busy=0, done=0, every grad_* element=0. rst wins over every other input, including mid-COMPUTE.
- History rows: r0 (oldest), r1, r2 (newest).
- Row accept: at an edge with state=IDLE and row_valid=1.
  - frame_start=1: r0=r1=r2=row_in.
  - frame_start=0: r0<=r1, r1<=r2, r2<=row_in.
  - row_valid with busy=1 is ignored. No history change, no queuing.
- FSM:
  - IDLE -> COMPUTE on accept, group g=0.
  - COMPUTE: each edge writes output columns g*LANES .. min(g*LANES+LANES, WIDTH-2)-1, then g++.
  - The edge writing the last group (NG=ceil((WIDTH-2)/LANES)) -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - done first visible NG cycles after the accepting edge (default 7).
  - Output elements hold between writes; unwritten columns keep their previous row's values until written.
- Output column j uses pixel columns j, j+1, j+2 of r0/r1/r2.
  - Gx = (r0[j+2]-r0[j]) + 2(r1[j+2]-r1[j]) + (r2[j+2]-r2[j])
  - Gy = (r0[j]+2r0[j+1]+r0[j+2]) - (r2[j]+2r2[j+1]+r2[j+2])
  - Exact, PIX_W+3 bits signed, no overflow possible.
- Magnitude: (|Gx|+|Gy|) >> MAG_SHIFT, saturated to 2^MAG_W-1.
- Angle, with ax=|Gx| and ay=|Gy|:
  - 5*ay < 2*ax -> 0 (horizontal gradient)
  - else 2*ay > 5*ax -> 2 (vertical)
  - else Gx, Gy same sign (or either zero) -> 1 (45°)
  - else -> 3 (135°)
  - Gx=Gy=0 -> 0.
- Simultaneous row_valid and DONE: ignored; the source must wait for busy=0.

Optional Feature:
GRADIENT_THRESH_EN:
- Defined: adds input thresh [MAG_W] and output edge_map [WIDTH-2].
  - edge_map[j] = (mag_j > thresh), written in the same cycle as grad_mag[j].
  - thresh is sampled at the accept edge and held for the row.
  - Reset value 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- rst high 2 cycles, then low -> busy=0, done=0, all grad_*=0. row_valid with rst high -> ignored.
- frame_start row all 100 -> done 7 cycles after accept; all 14 columns Gx=0, Gy=0, mag=0, angle=0.
- frame_start row pixel[i]=10*i -> every column Gx=80, Gy=0, mag=10, angle=0.
- frame_start row all 0, then row all 200 (frame_start=0) -> Gx=0, Gy=-800, mag=100, angle=2. Same with MAG_SHIFT=0 -> mag=255 (saturation).
- frame_start row 10*i, then row 10*i+10 -> Gx=80, Gy=-40, mag=15, angle=3. Repeat with LANES=1 and LANES=14 -> identical values, done at 14 and 1 cycles respectively.
- row_valid pulsed during COMPUTE -> ignored, history unchanged. rst asserted at cycle 3 of COMPUTE -> next cycle IDLE, outputs 0, no done pulse. With GRADIENT_THRESH_EN, thresh=12 on the ramp row -> edge_map all 0; thresh=9 -> all 1.
